cache_controller: RTL and testbench
===================================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 The block SHALL have parameter INDEX_BITS, default 6, giving the log2 number of cache lines (64 lines of one 32-bit word each).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-low reset.
REQ-004 wr_en  input  1  memory-stage store request.
REQ-005 rd_en  input  1  memory-stage load request.
REQ-006 address  input  32  byte address; bits [1:0] ignored.
REQ-007 write_data  input  32  store data.
REQ-008 read_data  output  32  load data, valid when ready=1 and the request is a load.
REQ-009 ready  output  1  request complete / no request; the pipeline freezes while ready=0.
REQ-010 sram_wr_en  output  1  write request to the SRAM controller.
REQ-011 sram_rd_en  output  1  read request to the SRAM controller.
REQ-012 sram_address  output  32  address to the SRAM controller, equal to address.
REQ-013 sram_write_data  output  32  equal to write_data.
REQ-014 sram_read_data  input  32  word returned by the SRAM controller.
REQ-015 sram_ready  input  1  SRAM controller completion pulse, one cycle.

Function
REQ-016 The cache SHALL be direct-mapped and write-through, with:
- index = address[INDEX_BITS+1:2]
- tag = address[18:INDEX_BITS+2]
- per line: valid bit, tag, 32-bit data.
REQ-017 hit SHALL be combinational: the indexed line is valid and its stored tag equals the address tag.
REQ-018 The FSM SHALL have states IDLE, READ_MISS and WRITE.
REQ-019 In IDLE, wr_en=1 SHALL go to WRITE next cycle; wr_en has priority when wr_en=rd_en=1.
REQ-020 In IDLE, rd_en=1, wr_en=0 and hit=1 SHALL give, in the same cycle:
- ready=1
- read_data = line data
- no SRAM request
- the state remains IDLE.
REQ-021 In IDLE, rd_en=1, wr_en=0 and hit=0 SHALL give ready=0 and go to READ_MISS next cycle.
REQ-022 In IDLE with no request, ready SHALL be 1.
REQ-023 In READ_MISS, sram_rd_en SHALL be held at 1 until the cycle sram_ready=1. That cycle:
- read_data = sram_read_data
- ready=1
- on the clock edge, the line is written with data, tag and valid=1
- next state IDLE.
REQ-024 In WRITE, sram_wr_en SHALL be held at 1 until the cycle sram_ready=1. That cycle:
- ready=1
- if hit, the line data is updated to write_data; a miss does not allocate
- next state IDLE.
REQ-025 ready SHALL be 0 in READ_MISS and WRITE except in the sram_ready cycle; sram_ready is ignored in IDLE.
REQ-026 sram_rd_en and sram_wr_en SHALL never both be 1, and both SHALL be 0 in IDLE.
REQ-027 read_data SHALL be 0 whenever REQ-020 or REQ-023 does not apply.
REQ-028 Upstream holds wr_en, rd_en, address and write_data stable while ready=0; the block need not register them.
REQ-029 Miss latency SHALL be 1 cycle plus the SRAM controller latency; the hit latency is 0 extra cycles.

Reset
REQ-030 With rst=0 at a clock edge, the block SHALL:
- go to IDLE
- clear all valid bits
- drive sram_rd_en=0, sram_wr_en=0 and read_data=0 from the next cycle
- drive ready=1 if no request is present.
REQ-031 Reset during READ_MISS or WRITE SHALL abandon the access without a line update; the SRAM controller is reset by the same rst.
REQ-032 Tag and data arrays need not be reset.

Verification
REQ-033 Read 0x100 after reset with SRAM returning 0xDEADBEEF after 3 cycles -> the bench SHALL see:
- ready=0 for 4 cycles
- then ready=1 with read_data=0xDEADBEEF.
REQ-034 Repeat the read of 0x100 -> ready=1 and read_data=0xDEADBEEF in the same cycle, with sram_rd_en never asserted.
REQ-035 Write 0x12345678 to 0x100 (hit), then read 0x100 -> the bench SHALL see:
- sram_wr_en held until sram_ready
- the following read hits, returning 0x12345678.
REQ-036 Read 0x200 (conflict with 0x100, same index 0) -> miss, SRAM read issued, line replaced; a later read of 0x100 misses again.
REQ-037 Write to uncached 0x300, then read 0x300 -> the write does not allocate and the read misses.
REQ-038 rst=0 asserted mid-READ_MISS -> the bench SHALL see:
- next cycle state IDLE and sram_rd_en=0
- a subsequent read of 0x100 misses.

Source files
------------

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, one-word-per-line cache sitting between the
// pipeline memory stage and an SRAM controller. Loads that hit complete in the
// same cycle; misses fetch the word from SRAM and fill the line. Stores always
// go to SRAM and update the line only on a hit (no write-allocate).
module cache_controller #(
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,

    // Pipeline side
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,

    // SRAM controller side
    output logic        sram_wr_en,
    output logic        sram_rd_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_write_data,
    input  logic [31:0] sram_read_data,
    input  logic        sram_ready
);

    localparam int unsigned Lines = 1 << INDEX_BITS;
    // Tag covers address bits [18:INDEX_BITS+2]; upper bits are not cached.
    localparam int unsigned TagW  = 17 - INDEX_BITS;

    typedef enum logic [1:0] {
        StIdle,
        StReadMiss,
        StWrite
    } state_e;

    state_e state_q, state_d;

    logic [Lines-1:0] valid_q;
    logic [TagW-1:0]  tag_q  [Lines];
    logic [31:0]      data_q [Lines];

    logic [INDEX_BITS-1:0] index;
    logic [TagW-1:0]       addr_tag;
    logic                  hit;
    logic                  fill_en;
    logic                  upd_en;

    // Address bits outside index/tag carry no information for the cache.
    logic unused_addr;
    assign unused_addr = ^{address[31:19], address[1:0]};

    assign index    = address[INDEX_BITS+1:2];
    assign addr_tag = address[18:INDEX_BITS+2];
    assign hit      = valid_q[index] && (tag_q[index] == addr_tag);

    // The SRAM sees the pipeline request unmodified; upstream holds it stable.
    assign sram_address    = address;
    assign sram_write_data = write_data;

    // Next-state and output decode; everything defaults to the quiet value.
    always_comb begin
        state_d    = state_q;
        ready      = 1'b0;
        read_data  = 32'h0;
        sram_rd_en = 1'b0;
        sram_wr_en = 1'b0;
        fill_en    = 1'b0;
        upd_en     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (wr_en) begin
                    // Stores win over loads when both are requested.
                    state_d = StWrite;
                end else if (rd_en) begin
                    if (hit) begin
                        ready     = 1'b1;
                        read_data = data_q[index];
                    end else begin
                        state_d = StReadMiss;
                    end
                end else begin
                    ready = 1'b1;
                end
            end

            StReadMiss: begin
                sram_rd_en = 1'b1;
                if (sram_ready) begin
                    ready     = 1'b1;
                    read_data = sram_read_data;
                    fill_en   = 1'b1;
                    state_d   = StIdle;
                end
            end

            StWrite: begin
                sram_wr_en = 1'b1;
                if (sram_ready) begin
                    ready   = 1'b1;
                    upd_en  = hit;
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Valid bits are the only array state that reset clears.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[index] <= 1'b1;
        end
    end

    // Tag/data arrays: fill on read miss, update on write hit; an access cut
    // short by reset leaves the line untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (fill_en) begin
                tag_q[index]  <= addr_tag;
                data_q[index] <= sram_read_data;
            end else if (upd_en) begin
                data_q[index] <= write_data;
            end
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a fixed-latency SRAM model and a
// read-data scoreboard.
module tb_cache_controller;

    localparam int unsigned Lat = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic [31:0] read_data;
    logic        ready;
    logic        sram_wr_en;
    logic        sram_rd_en;
    logic [31:0] sram_address;
    logic [31:0] sram_write_data;
    logic [31:0] sram_read_data = 32'h0;
    logic        sram_ready = 1'b0;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    cache_controller #(
        .INDEX_BITS(6)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .rd_en          (rd_en),
        .address        (address),
        .write_data     (write_data),
        .read_data      (read_data),
        .ready          (ready),
        .sram_wr_en     (sram_wr_en),
        .sram_rd_en     (sram_rd_en),
        .sram_address   (sram_address),
        .sram_write_data(sram_write_data),
        .sram_read_data (sram_read_data),
        .sram_ready     (sram_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One pipeline access, started just after a rising edge. The SRAM model
    // raises sram_ready once the request has been seen for Lat cycles.
    task automatic access(input string tag, input bit is_wr, input bit also_rd,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input bit exp_miss, input logic [31:0] sdata,
                          input logic [31:0] exp_rdata);
        int   waits = 0;
        int   cnt = 0;
        bit   done = 1'b0;
        bit   req_seen;
        bit   saw_rd = 1'b0;
        bit   saw_wr = 1'b0;
        bit   both = 1'b0;
        bit   held_ok = 1'b1;
        bit   pass_ok = 1'b1;
        logic [31:0] exp;
        address    = addr;
        write_data = wdata;
        wr_en      = is_wr;
        rd_en      = !is_wr || also_rd;
        exp_q.push_back(exp_rdata);
        while (!done && waits < 40) begin
            @(negedge clk);
            req_seen = sram_rd_en | sram_wr_en;
            if (sram_rd_en) saw_rd = 1'b1;
            if (sram_wr_en) saw_wr = 1'b1;
            if (sram_rd_en && sram_wr_en) both = 1'b1;
            if (sram_address !== address || sram_write_data !== write_data) pass_ok = 1'b0;
            if (ready) begin
                exp = exp_q.pop_front();
                check({tag, " read_data"}, read_data, exp);
                done = 1'b1;
            end else begin
                if (waits > 0 && !(is_wr ? sram_wr_en : sram_rd_en)) held_ok = 1'b0;
                waits++;
            end
            @(posedge clk);
            #1;
            if (sram_ready) begin
                sram_ready = 1'b0;
            end else if (req_seen) begin
                if (cnt == Lat - 1) begin
                    sram_ready     = 1'b1;
                    sram_read_data = sdata;
                end else begin
                    cnt++;
                end
            end
        end
        if (!done) void'(exp_q.pop_front());
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        sram_ready = 1'b0;
        check({tag, " completed"}, 32'(done), 32'd1);
        check({tag, " wait cycles"}, 32'(waits), (is_wr || exp_miss) ? 32'(Lat + 1) : 32'd0);
        check({tag, " sram_rd seen"}, 32'(saw_rd), (!is_wr && exp_miss) ? 32'd1 : 32'd0);
        check({tag, " sram_wr seen"}, 32'(saw_wr), is_wr ? 32'd1 : 32'd0);
        check({tag, " req held"}, 32'(held_ok), 32'd1);
        check({tag, " rd&wr exclusive"}, 32'(both), 32'd0);
        check({tag, " sram passthru"}, 32'(pass_ok), 32'd1);
    endtask

    // One idle cycle: nothing requested, so ready=1 and everything quiet.
    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, " ready"}, 32'(ready), 32'd1);
        check({tag, " read_data"}, read_data, 32'h0);
        check({tag, " sram_rd_en"}, 32'(sram_rd_en), 32'd0);
        check({tag, " sram_wr_en"}, 32'(sram_wr_en), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        idle_check("reset");

        // Cold miss, then hit on the filled line.
        access("rd100 miss", 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF);
        access("rd100 hit", 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 32'hDEADBEEF);

        // Write hit updates the line; store result carries no read data.
        access("wr100", 1'b1, 1'b0, 32'h100, 32'h12345678, 1'b1, 32'h0, 32'h0);
        access("rd100 after wr", 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 32'h12345678);

        // Conflict on index 0 evicts 0x100.
        access("rd200 miss", 1'b0, 1'b0, 32'h200, 32'h0, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D);
        access("rd200 hit", 1'b0, 1'b0, 32'h200, 32'h0, 1'b0, 32'h0, 32'hCAFEF00D);
        access("rd100 evicted", 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'h12345678, 32'h12345678);

        // Write miss does not allocate.
        access("wr300", 1'b1, 1'b0, 32'h300, 32'hA5A5A5A5, 1'b1, 32'h0, 32'h0);
        access("rd300 miss", 1'b0, 1'b0, 32'h300, 32'h0, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5);

        // Store and load together: store wins, no allocation on this miss.
        access("wr+rd104", 1'b1, 1'b1, 32'h104, 32'h00000055, 1'b1, 32'h0, 32'h0);
        access("rd104 miss", 1'b0, 1'b0, 32'h104, 32'h0, 1'b1, 32'h00000055, 32'h00000055);
        access("rd104 hit", 1'b0, 1'b0, 32'h104, 32'h0, 1'b0, 32'h0, 32'h00000055);

        // Stray sram_ready while idle has no effect.
        sram_ready = 1'b1;
        idle_check("stray sram_ready");
        sram_ready = 1'b0;
        idle_check("after stray");

        // Refill 0x100, then reset in the middle of a miss on 0x108.
        access("rd100 refill", 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0BADF00D, 32'h0BADF00D);
        access("rd100 rehit", 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 32'h0BADF00D);
        address = 32'h108;
        rd_en   = 1'b1;
        @(negedge clk);
        check("mid-miss first ready", 32'(ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid-miss sram_rd_en", 32'(sram_rd_en), 32'd1);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle_check("after mid-miss rst");

        // Valid bits were cleared: 0x100 misses again.
        access("rd100 post rst", 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0BADF00D, 32'h0BADF00D);
        idle_check("final idle");

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
